// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb_pkg
// Brief    : Shared types and constants for the data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_CPU = 2'd1,
        GNT_DMA = 2'd2
    } state_t;

    localparam int PORT_CPU = 0;
    localparam int PORT_DMA = 1;

    localparam int DEF_AW = 8;
    localparam int DEF_DW = 16;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_starve_counter.sv
`default_nettype none
// ============================================================================
// Module   : starve_counter
// Brief    : Saturating DMA wait counter; hit flags that DMA must win next.
// Revision : 1.0 - initial release
// ============================================================================
module starve_counter #(
    parameter int MAX_WAIT = 4,
    parameter int CW       = 4
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          hit
);

    logic [CW-1:0] r_count;

    always_ff @(posedge Clk) begin
        if (Reset || clr) begin
            r_count <= '0;
        end else if (inc && (r_count < CW'(MAX_WAIT))) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;
    assign hit   = (r_count >= CW'(MAX_WAIT));

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-port (CPU/DMA) arbiter for the single-port data memory.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int MAX_WAIT = 4
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          cpu_req,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    input  logic          dma_req,
    input  logic          dma_wr,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    w_elig;
    logic          w_hit;
    logic          w_inc;
    logic          w_clr;
    logic [3:0]    w_unused_wait_cnt;
    logic          r_cpu_rvalid;
    logic          r_dma_rvalid;
    logic          r_mem_wr;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;

    // A port is masked while it is being granted, so a held request is served once.
    always_comb begin
        w_elig           = 2'b00;
        w_elig[PORT_CPU] = cpu_req && (r_state != GNT_CPU);
        w_elig[PORT_DMA] = dma_req && (r_state != GNT_DMA);
        w_next           = IDLE;
        if (w_elig[PORT_DMA] && w_hit) begin
            w_next = GNT_DMA;
        end else if (w_elig[PORT_CPU]) begin
            w_next = GNT_CPU;
        end else if (w_elig[PORT_DMA]) begin
            w_next = GNT_DMA;
        end
    end

    assign w_inc = dma_req && (w_next != GNT_DMA);
    assign w_clr = !dma_req || (w_next == GNT_DMA);

    starve_counter #(
        .MAX_WAIT (MAX_WAIT),
        .CW       (4)
    ) u_starve (
        .Clk   (Clk),
        .Reset (Reset),
        .inc   (w_inc),
        .clr   (w_clr),
        .count (w_unused_wait_cnt),
        .hit   (w_hit)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_cpu_rvalid <= 1'b0;
            r_dma_rvalid <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_state      <= w_next;
            r_cpu_rvalid <= (r_state == GNT_CPU) && !r_mem_wr;
            r_dma_rvalid <= (r_state == GNT_DMA) && !r_mem_wr;
            case (w_next)
                GNT_CPU: begin
                    r_mem_addr  <= cpu_addr;
                    r_mem_wr    <= cpu_wr;
                    r_mem_wdata <= cpu_wdata;
                end
                GNT_DMA: begin
                    r_mem_addr  <= dma_addr;
                    r_mem_wr    <= dma_wr;
                    r_mem_wdata <= dma_wdata;
                end
                default: begin
                    r_mem_wr    <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_gnt    = (r_state == GNT_CPU);
    assign dma_gnt    = (r_state == GNT_DMA);
    assign cpu_rvalid = r_cpu_rvalid;
    assign dma_rvalid = r_dma_rvalid;
    assign rdata      = mem_rdata;
    assign mem_addr   = r_mem_addr;
    assign mem_wr     = r_mem_wr;
    assign mem_wdata  = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Scoreboard bench for dmem_arbiter with a behavioural memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int AW       = 8;
    localparam int DW       = 16;
    localparam int MAX_WAIT = 4;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } acc_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req = 1'b0, cpu_wr = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          dma_req = 1'b0, dma_wr = 1'b0;
    logic [AW-1:0] dma_addr = '0;
    logic [DW-1:0] dma_wdata = '0;
    logic          cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_wr;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .Clk        (clk),
        .Reset      (rst),
        .cpu_req    (cpu_req),
        .cpu_wr     (cpu_wr),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .dma_req    (dma_req),
        .dma_wr     (dma_wr),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .rdata      (rdata),
        .mem_addr   (mem_addr),
        .mem_wr     (mem_wr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Synchronous-read data memory seen by the arbiter.
    logic [DW-1:0] mem     [0:255];
    logic [DW-1:0] ref_mem [0:255];

    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    int   checks = 0;
    int   failures = 0;
    acc_t cpu_q[$];
    acc_t dma_q[$];
    bit   mon_en = 1'b0;
    bit   cpu_busy = 1'b0, dma_busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference expectations for the next cycle, derived from the arbitration rules.
    logic [1:0]    exp_g = 2'b00;
    int            exp_rv = 0;
    logic [DW-1:0] exp_rdata = '0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_wdata = '0;
    int            wait_m = 0;
    bit            out_c = 1'b0, out_d = 1'b0;
    int            age_c = 0, age_d = 0;

    always @(negedge clk) begin : monitor
        acc_t       a;
        logic [1:0] nxt;
        bit         ce, de, have;
        if (mon_en) begin
            chk("gnt_pair", 32'({cpu_gnt, dma_gnt}), 32'(exp_g));
            chk("cpu_rvalid", 32'(cpu_rvalid), 32'(exp_rv == 1));
            chk("dma_rvalid", 32'(dma_rvalid), 32'(exp_rv == 2));
            if (exp_rv != 0) chk("rdata", 32'(rdata), 32'(exp_rdata));
            chk("wait_cnt", 32'(dut.u_starve.count), 32'(wait_m));
            exp_rv = 0;

            if (cpu_gnt || dma_gnt) begin
                have = cpu_gnt ? (cpu_q.size() != 0) : (dma_q.size() != 0);
                if (!have) begin
                    checks++;
                    failures++;
                    $display("FAIL gnt_without_request actual=granted required=pending t=%0t", $time);
                end else begin
                    if (cpu_gnt) a = cpu_q.pop_front();
                    else         a = dma_q.pop_front();
                    chk("mem_addr", 32'(mem_addr), 32'(a.addr));
                    chk("mem_wr", 32'(mem_wr), 32'(a.wr));
                    chk("mem_wdata", 32'(mem_wdata), 32'(a.wdata));
                    exp_addr  = a.addr;
                    exp_wdata = a.wdata;
                    if (a.wr) begin
                        ref_mem[a.addr] = a.wdata;
                    end else begin
                        exp_rv    = cpu_gnt ? 1 : 2;
                        exp_rdata = ref_mem[a.addr];
                    end
                end
            end else begin
                chk("idle_mem_wr", 32'(mem_wr), 32'd0);
                chk("idle_mem_addr", 32'(mem_addr), 32'(exp_addr));
                chk("idle_mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
            end

            // Held-request discipline and grant latency bounds.
            if (out_c) begin
                if (cpu_gnt) begin
                    out_c = 1'b0;
                    chk("cpu_latency_ok", 32'(age_c <= 1), 32'd1);
                end else begin
                    age_c++;
                    chk("cpu_req_held", 32'(cpu_req), 32'd1);
                end
            end else if (cpu_req && !cpu_gnt) begin
                out_c = 1'b1;
                age_c = 0;
            end
            if (out_d) begin
                if (dma_gnt) begin
                    out_d = 1'b0;
                    chk("dma_latency_ok", 32'(age_d <= MAX_WAIT), 32'd1);
                end else begin
                    age_d++;
                    chk("dma_req_held", 32'(dma_req), 32'd1);
                end
            end else if (dma_req && !dma_gnt) begin
                out_d = 1'b1;
                age_d = 0;
            end

            ce = cpu_req && !cpu_gnt;
            de = dma_req && !dma_gnt;
            if (de && wait_m >= MAX_WAIT) nxt = 2'b01;
            else if (ce)                   nxt = 2'b10;
            else if (de)                   nxt = 2'b01;
            else                           nxt = 2'b00;
            if (!dma_req || nxt == 2'b01) wait_m = 0;
            else if (wait_m < MAX_WAIT)   wait_m++;
            exp_g = nxt;

            if (rst) begin
                exp_g     = 2'b00;
                exp_rv    = 0;
                exp_addr  = '0;
                exp_wdata = '0;
                wait_m    = 0;
                out_c     = 1'b0;
                out_d     = 1'b0;
            end
        end
    end

    task automatic issue_cpu(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        acc_t a;
        a.wr = wr; a.addr = addr; a.wdata = wd;
        cpu_q.push_back(a);
        cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wd;
        cpu_busy = 1'b1;
    endtask

    task automatic issue_dma(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        acc_t a;
        a.wr = wr; a.addr = addr; a.wdata = wd;
        dma_q.push_back(a);
        dma_req = 1'b1; dma_wr = wr; dma_addr = addr; dma_wdata = wd;
        dma_busy = 1'b1;
    endtask

    // Advance one cycle; a request is released only after its grant pulse was seen.
    task automatic tick();
        bit gc, gd;
        @(negedge clk);
        gc = cpu_gnt;
        gd = dma_gnt;
        @(posedge clk);
        #1;
        if (gc) begin cpu_busy = 1'b0; cpu_req = 1'b0; end
        if (gd) begin dma_busy = 1'b0; dma_req = 1'b0; end
    endtask

    task automatic random_phase(input int cycles, input int pc, input int pd);
        for (int n = 0; n < cycles; n++) begin
            tick();
            if (!cpu_busy && $urandom_range(0, 9) < pc)
                issue_cpu(1'($urandom_range(0, 1)), 8'(8'h20 + $urandom_range(0, 7)), 16'($urandom));
            if (!dma_busy && $urandom_range(0, 9) < pd)
                issue_dma(1'($urandom_range(0, 1)), 8'(8'h20 + $urandom_range(0, 7)), 16'($urandom));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 16'(i * 7 + 3);
            ref_mem[i] = 16'(i * 7 + 3);
        end
        mem[8'h10]     = 16'hBEEF;
        ref_mem[8'h10] = 16'hBEEF;

        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // CPU read of a preloaded word.
        issue_cpu(1'b0, 8'h10, 16'h0000);
        repeat (4) tick();

        // Simultaneous write (CPU) and read-back (DMA) of the same word.
        issue_cpu(1'b1, 8'h22, 16'h1234);
        issue_dma(1'b0, 8'h22, 16'h0000);
        repeat (5) tick();

        // Reset arrives during the grant cycle of a CPU read.
        issue_cpu(1'b0, 8'h30, 16'h0000);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // Quiet bus.
        repeat (10) tick();

        random_phase(200, 10, 10);
        random_phase(100, 10, 0);
        random_phase(100, 0, 10);
        random_phase(300, 5, 5);

        repeat (8) tick();
        chk("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
        chk("dma_q_drained", 32'(dma_q.size()), 32'd0);
        chk("wait_cnt_final", 32'(dut.u_starve.count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
